// File: rtl/vga_stream_out_if.sv
// Pixel stream bundle feeding the VGA output stage.
// 24-bit RGB beats with valid/ready handshake and start/end-of-frame framing.
interface vga_stream_out_if;
   logic [23:0] in_data;
   logic        in_valid;
   logic        in_sop;
   logic        in_eop;
   logic        in_ready;

   modport master (
      output in_data, in_valid, in_sop, in_eop,
      input  in_ready
   );

   modport slave (
      input  in_data, in_valid, in_sop, in_eop,
      output in_ready
   );
endinterface

// File: rtl/vga_stream_out.sv
// VGA output stage: aligns an RGB pixel stream to a 640x480@60 raster and
// drives an ADV7123-style DAC. The pixel rate is half of clk via the pe strobe.
// On underflow or bad framing the visible area shows ERR_RGB until the next
// start-of-packet is caught at the raster origin.
// Optional: define VGA_STREAM_OUT_ERR_CNT_EN to add a saturating err_count
// output that counts ACTIVE->RESYNC transitions.
//
// state      | meaning
// RESYNC     | discard non-sop beats, hold a sop beat and move on
// WAIT_FRAME | hold sop until the raster origin slot, then consume it there
// ACTIVE     | one beat consumed per visible pixel, framing checked
module vga_stream_out #(
   parameter int          H_ACTIVE = 640,
   parameter int          H_FRONT  = 16,
   parameter int          H_SYNC   = 96,
   parameter int          H_BACK   = 48,
   parameter int          V_ACTIVE = 480,
   parameter int          V_FRONT  = 10,
   parameter int          V_SYNC   = 2,
   parameter int          V_BACK   = 33,
   parameter logic [23:0] ERR_RGB  = 24'h0000FF
) (
   input  logic             clk,
   input  logic             reset_n,
   vga_stream_out_if.slave  st,
   output logic             VGA_CLK,
   output logic             VGA_HS,
   output logic             VGA_VS,
   output logic             VGA_BLANK,
   output logic             VGA_SYNC,
   output logic [7:0]       VGA_R,
   output logic [7:0]       VGA_G,
   output logic [7:0]       VGA_B
`ifdef VGA_STREAM_OUT_ERR_CNT_EN
   ,
   output logic [15:0]      err_count
`endif
);

   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] H_PIX_LS = 10'(H_ACTIVE - 1);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] V_PIX_LS = 10'(V_ACTIVE - 1);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

   typedef enum logic [1:0] {RESYNC, WAIT_FRAME, ACTIVE} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        pe;
   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic        vis;
   logic        origin;
   logic        last_pix;
   logic        slot;
   logic        in_ready_c;
   logic [23:0] rgb_nxt;

   assign vis      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign origin   = (h_cnt == 10'd0) && (v_cnt == 10'd0);
   assign last_pix = (h_cnt == H_PIX_LS) && (v_cnt == V_PIX_LS);

   // Pixel enable and raster counters; they never depend on the stream.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pe    <= 1'b0;
         h_cnt <= 10'd0;
         v_cnt <= 10'd0;
      end else begin
         pe <= ~pe;
         if (pe) begin
            if (h_cnt == H_LAST) begin
               h_cnt <= 10'd0;
               v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
               h_cnt <= h_cnt + 10'd1;
            end
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset_n) state <= RESYNC;
      else          state <= state_nxt;
   end

   // Next state, ready and pixel colour for the current consume slot.
   always_comb begin
      state_nxt  = state;
      in_ready_c = 1'b0;
      slot       = 1'b0;
      rgb_nxt    = ERR_RGB;
      case (state)
         RESYNC: begin
            in_ready_c = !(st.in_valid && st.in_sop);
            if (st.in_valid && st.in_sop) state_nxt = WAIT_FRAME;
         end
         WAIT_FRAME: begin
            slot       = pe && origin;
            in_ready_c = slot;
         end
         ACTIVE: begin
            slot       = pe && vis;
            in_ready_c = slot;
         end
         default: state_nxt = RESYNC;
      endcase
      // Faulty beats are still displayed; an empty slot shows ERR_RGB.
      if (slot) begin
         if (!st.in_valid) begin
            state_nxt = RESYNC;
         end else begin
            rgb_nxt = st.in_data;
            if ((st.in_sop != origin) || (st.in_eop != last_pix)) state_nxt = RESYNC;
            else                                                  state_nxt = ACTIVE;
         end
      end
   end

   assign st.in_ready = reset_n && in_ready_c;
   assign VGA_SYNC    = 1'b0;

   // Registered DAC outputs, refreshed at the end of each pe cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         VGA_CLK   <= 1'b1;
         VGA_HS    <= 1'b1;
         VGA_VS    <= 1'b1;
         VGA_BLANK <= 1'b0;
         VGA_R     <= 8'd0;
         VGA_G     <= 8'd0;
         VGA_B     <= 8'd0;
      end else begin
         VGA_CLK <= ~pe;
         if (pe) begin
            VGA_HS    <= !((h_cnt >= HS_START) && (h_cnt <= HS_END));
            VGA_VS    <= !((v_cnt >= VS_START) && (v_cnt <= VS_END));
            VGA_BLANK <= vis;
            {VGA_R, VGA_G, VGA_B} <= vis ? rgb_nxt : 24'd0;
         end
      end
   end

`ifdef VGA_STREAM_OUT_ERR_CNT_EN
   // Saturating count of stream faults seen while locked.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         err_count <= 16'd0;
      end else if ((state == ACTIVE) && (state_nxt == RESYNC) && (err_count != 16'hFFFF)) begin
         err_count <= err_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_stream_out.sv
// Directed bench for vga_stream_out. A full-size instance checks reset values,
// line timing and mid-line reset; a reduced-geometry instance (16x8 raster,
// 8x4 visible) checks streaming, faults and resync within a short run.
module tb_vga_stream_out;

   localparam int SHA = 8;
   localparam int SHF = 2;
   localparam int SHS = 3;
   localparam int SHB = 3;
   localparam int SVA = 4;
   localparam int SVF = 1;
   localparam int SVS = 2;
   localparam int SVB = 1;
   localparam int SHT = SHA + SHF + SHS + SHB;
   localparam int SVT = SVA + SVF + SVS + SVB;
   localparam logic [23:0] ERR = 24'h0000FF;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic f_rst_n;
   logic s_rst_n;

   vga_stream_out_if f_if();
   vga_stream_out_if s_if();

   logic       f_vclk, f_hs, f_vs, f_blank, f_sync;
   logic [7:0] f_r, f_g, f_b;
   logic       s_vclk, s_hs, s_vs, s_blank, s_sync;
   logic [7:0] s_r, s_g, s_b;
`ifdef VGA_STREAM_OUT_ERR_CNT_EN
   logic [15:0] f_ec;
   logic [15:0] s_ec;
`endif

   vga_stream_out u_full (
      .clk       (clk),
      .reset_n   (f_rst_n),
      .st        (f_if),
      .VGA_CLK   (f_vclk),
      .VGA_HS    (f_hs),
      .VGA_VS    (f_vs),
      .VGA_BLANK (f_blank),
      .VGA_SYNC  (f_sync),
      .VGA_R     (f_r),
      .VGA_G     (f_g),
      .VGA_B     (f_b)
`ifdef VGA_STREAM_OUT_ERR_CNT_EN
      ,
      .err_count (f_ec)
`endif
   );

   vga_stream_out #(
      .H_ACTIVE (SHA), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
      .V_ACTIVE (SVA), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB)
   ) u_small (
      .clk       (clk),
      .reset_n   (s_rst_n),
      .st        (s_if),
      .VGA_CLK   (s_vclk),
      .VGA_HS    (s_hs),
      .VGA_VS    (s_vs),
      .VGA_BLANK (s_blank),
      .VGA_SYNC  (s_sync),
      .VGA_R     (s_r),
      .VGA_G     (s_g),
      .VGA_B     (s_b)
`ifdef VGA_STREAM_OUT_ERR_CNT_EN
      ,
      .err_count (s_ec)
`endif
   );

   int n_vec = 0;
   int n_err = 0;
   int fe;
   int src_x, src_y, gcnt, sm_h, sm_v, last_h, last_v;
   bit sm_pe, garbage, exp_stream, stall_arm, stall_hit, early_arm, eop_hit, last_acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic run_f(input int e);
      while (fe < e) begin
         @(posedge clk);
         fe++;
      end
      @(negedge clk);
   endtask

   task automatic chk_f_reset(input string tag);
      chk({tag, "_vclk"},  f_vclk, 1);
      chk({tag, "_hs"},    f_hs, 1);
      chk({tag, "_vs"},    f_vs, 1);
      chk({tag, "_blank"}, f_blank, 0);
      chk({tag, "_rgb"},   {f_r, f_g, f_b}, 0);
      chk({tag, "_sync"},  f_sync, 0);
      chk({tag, "_rdy"},   f_if.in_ready, 0);
`ifdef VGA_STREAM_OUT_ERR_CNT_EN
      chk({tag, "_ec"},    f_ec, 0);
`endif
   endtask

   // One clk of the small instance: drive source, check ready, then outputs.
   task automatic step_s();
      logic [23:0] d;
      logic [23:0] exp_rgb;
      logic        sop, eop, val, rdy, acc, pe_b, vis_b, aligned;
      int          h_b, v_b;
      if (garbage) begin
         d   = {8'hDE, gcnt[7:0], 8'h5A};
         sop = 1'b0;
         eop = 1'b0;
         val = 1'b1;
      end else begin
         d   = {src_x[7:0], src_y[7:0], 8'hA5};
         sop = (src_x == 0) && (src_y == 0);
         eop = ((src_x == SHA - 1) && (src_y == SVA - 1)) ||
               (early_arm && (src_x == SHA - 2) && (src_y == SVA - 1));
         val = !(stall_arm && (src_x == 3) && (src_y == 1));
      end
      s_if.in_data  = d;
      s_if.in_sop   = sop;
      s_if.in_eop   = eop;
      s_if.in_valid = val;
      #1;
      rdy     = s_if.in_ready;
      acc     = val && rdy;
      pe_b    = sm_pe;
      h_b     = sm_h;
      v_b     = sm_v;
      vis_b   = (h_b < SHA) && (v_b < SVA);
      aligned = pe_b && (h_b == src_x) && (v_b == src_y);
      if (garbage)            chk("s_rdy_garbage", rdy, 1);
      else if (exp_stream)    chk("s_rdy_stream", rdy, pe_b && vis_b);
      else if (val && !aligned) chk("s_rdy_hold", rdy, 0);
      @(posedge clk);
      if (sm_pe) begin
         if (sm_h == SHT - 1) begin
            sm_h = 0;
            sm_v = (sm_v == SVT - 1) ? 0 : sm_v + 1;
         end else begin
            sm_h++;
         end
      end
      sm_pe = !sm_pe;
      @(negedge clk);
      chk("s_vclk", s_vclk, !pe_b);
      if (pe_b) begin
         chk("s_hs", s_hs, !((h_b >= SHA + SHF) && (h_b <= SHA + SHF + SHS - 1)));
         chk("s_vs", s_vs, !((v_b >= SVA + SVF) && (v_b <= SVA + SVF + SVS - 1)));
         chk("s_blank", s_blank, vis_b);
         exp_rgb = !vis_b ? 24'd0 : ((acc && !garbage) ? d : ERR);
         chk("s_rgb", {s_r, s_g, s_b}, exp_rgb);
      end
      last_acc = acc && !garbage;
      last_h   = h_b;
      last_v   = v_b;
      if (acc && !garbage) begin
         if (eop) begin
            if (early_arm) begin
               early_arm = 1'b0;
               eop_hit   = 1'b1;
            end
            src_x = 0;
            src_y = 0;
         end else if (src_x == SHA - 1) begin
            src_x = 0;
            src_y++;
         end else begin
            src_x++;
         end
      end
      if (stall_arm && !val && pe_b && vis_b && (h_b == 3) && (v_b == 1)) begin
         stall_arm = 1'b0;
         stall_hit = 1'b1;
         src_x     = 0;
         src_y     = 0;
      end
      if (garbage) gcnt++;
   endtask

   task automatic wait_origin(input string tag);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         step_s();
         if (last_acc) got = 1'b1;
      end
      chk(tag, {11'd0, got, last_h[9:0], last_v[9:0]}, {11'd0, 1'b1, 10'd0, 10'd0});
   endtask

   initial begin
      f_rst_n = 1'b0;
      s_rst_n = 1'b0;
      f_if.in_data = 24'd0; f_if.in_valid = 1'b0; f_if.in_sop = 1'b0; f_if.in_eop = 1'b0;
      s_if.in_data = 24'd0; s_if.in_valid = 1'b0; s_if.in_sop = 1'b0; s_if.in_eop = 1'b0;
      garbage = 0; exp_stream = 0; stall_arm = 0; stall_hit = 0; early_arm = 0; eop_hit = 0;
      src_x = 0; src_y = 0; gcnt = 0;

      // Full-size raster: reset values, idle RESYNC, line timing.
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk_f_reset("f_rst");
      f_rst_n = 1'b1;
      fe = -1;
      #1;
      chk("f_rdy_resync", f_if.in_ready, 1);
      run_f(0);
      chk("f_vclk_e0", f_vclk, 1);
      chk("f_blank_e0", f_blank, 0);
      run_f(1);
      chk("f_vclk_e1", f_vclk, 0);
      chk("f_blank_e1", f_blank, 1);
      chk("f_rgb_err", {f_r, f_g, f_b}, ERR);
      chk("f_hs_e1", f_hs, 1);
      run_f(2);
      chk("f_vclk_e2", f_vclk, 1);
      run_f(1279);
      chk("f_blank_639", f_blank, 1);
      run_f(1281);
      chk("f_blank_640", f_blank, 0);
      chk("f_rgb_640", {f_r, f_g, f_b}, 0);
      run_f(1312);
      chk("f_hs_655", f_hs, 1);
      run_f(1313);
      chk("f_hs_656", f_hs, 0);
      run_f(1503);
      chk("f_hs_751", f_hs, 0);
      run_f(1505);
      chk("f_hs_752", f_hs, 1);
      chk("f_vs_line0", f_vs, 1);
      chk("f_sync", f_sync, 0);

      // Reset pulsed mid-line at h=300 of line 1.
      run_f(2200);
      chk("f_blank_pre_rst", f_blank, 1);
      f_rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_f_reset("f_mid_rst");
      f_rst_n = 1'b1;
      fe = -1;
      run_f(1);
      chk("f_restart_blank", f_blank, 1);
      chk("f_restart_rgb", {f_r, f_g, f_b}, ERR);
      run_f(1281);
      chk("f_restart_blank640", f_blank, 0);
      run_f(1313);
      chk("f_restart_hs", f_hs, 0);

      // Small raster: reset values before release.
      chk("s_rst_vclk", s_vclk, 1);
      chk("s_rst_hs", s_hs, 1);
      chk("s_rst_vs", s_vs, 1);
      chk("s_rst_blank", s_blank, 0);
      chk("s_rst_rgb", {s_r, s_g, s_b}, 0);
      chk("s_rst_rdy", s_if.in_ready, 0);
      chk("s_rst_sync", s_sync, 0);
      s_rst_n = 1'b1;
      sm_pe = 1'b0; sm_h = 0; sm_v = 0;

      // Garbage beats consumed, then sop held until the origin slot.
      garbage = 1'b1;
      repeat (200) step_s();
      garbage = 1'b0;
      src_x = 0; src_y = 0;
`ifdef VGA_STREAM_OUT_ERR_CNT_EN
      chk("s_ec_garbage", s_ec, 0);
`endif
      wait_origin("s_origin_after_garbage");

      // Three well-formed frames; every visible slot must be consumed.
      exp_stream = 1'b1;
      repeat (3 * SHT * SVT * 2 - 1) step_s();

      // Source stall at (3,1).
      stall_arm = 1'b1;
      for (int i = 0; i < 600 && !stall_hit; i++) step_s();
      exp_stream = 1'b0;
      chk("s_stall_seen", stall_hit, 1);
      step_s();
      step_s();
      chk("s_rgb_after_stall", {s_r, s_g, s_b}, ERR);
`ifdef VGA_STREAM_OUT_ERR_CNT_EN
      chk("s_ec_stall", s_ec, 1);
`endif
      wait_origin("s_origin_after_stall");

      // Early eop on (6,3).
      exp_stream = 1'b1;
      early_arm  = 1'b1;
      for (int i = 0; i < 400 && !eop_hit; i++) step_s();
      exp_stream = 1'b0;
      chk("s_early_eop_seen", eop_hit, 1);
      step_s();
      step_s();
      chk("s_rgb_after_eop", {s_r, s_g, s_b}, ERR);
`ifdef VGA_STREAM_OUT_ERR_CNT_EN
      chk("s_ec_eop", s_ec, 2);
`endif
      wait_origin("s_origin_after_eop");
      exp_stream = 1'b1;
      repeat (SHT * SVT * 2) step_s();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vga_stream_out.md
# vga_stream_out

Terminal display stage of the scaler video pipeline: consumes the filtered 24-bit RGB pixel stream (valid/ready with start/end-of-packet framing) and drives the ADV7123 DAC at 640x480@60. Timing comes from a divide-by-2 pixel enable off the 50 MHz system clock. The block aligns each incoming frame to the raster origin. On underflow or malformed framing it blanks to a fixed colour and resynchronises on the next start-of-packet.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FRONT, 10; V_SYNC, 2; V_BACK, 33, vertical porches/sync (lines)
- ERR_RGB, 24'h0000FF, colour shown after a stream fault

- clk  in  1  50 MHz system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- in_data  in  24  pixel {R[23:16],G[15:8],B[7:0]}
- in_valid  in  1  in_data valid
- in_sop  in  1  beat is pixel (0,0) of a frame
- in_eop  in  1  beat is pixel (H_ACTIVE-1,V_ACTIVE-1)
- in_ready  out  1  block accepts beat this cycle
- VGA_CLK  out  1  pixel clock to DAC
- VGA_HS, VGA_VS  out  1  syncs, active low
- VGA_BLANK  out  1  BLANK_N, low outside visible area
- VGA_SYNC  out  1  constant 0
- VGA_R, VGA_G, VGA_B  out  8  colour

## Operation
- pe: toggles every clk; h_cnt 0..799, v_cnt 0..524 advance only when pe=1. h_cnt wraps 799->0 and then increments v_cnt; v_cnt wraps 524->0.
- vis = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- HS low for h_cnt in [656,751]. VS low for v_cnt in [490,491].
- FSM, reset state RESYNC:
  - RESYNC: in_ready = !(in_valid && in_sop); non-sop beats are discarded. When a valid sop beat is presented it is held unconsumed and the FSM goes to WAIT_FRAME.
  - WAIT_FRAME: in_ready=0. On the pe=1 cycle with h_cnt=0,v_cnt=0 the FSM enters ACTIVE and that cycle already counts as a consume slot.
  - ACTIVE: in_ready = pe && vis. In a slot, valid=1 consumes the beat and drives its RGB.
    - valid=0 in a slot is an underflow: drive ERR_RGB and go to RESYNC.
    - sop on a beat other than (0,0), or eop on a beat other than (639,479): beat is displayed, then the FSM goes to RESYNC.
    - Missing eop on (639,479): go to RESYNC.
    - Correct eop: stay in ACTIVE for the next frame, which must start with sop at (0,0). A missing sop there counts as a fault.
- In RESYNC/WAIT_FRAME, visible pixels show ERR_RGB; sync timing is never disturbed.
- Outside the visible area, RGB=0.

## Timing
- Reset values: pe=0, h_cnt=v_cnt=0, VGA_CLK=1, HS=VS=1, BLANK=0, RGB=0, SYNC=0, in_ready=0 for the reset cycle.
- All VGA_* outputs are registered and updated on the clk edge that ends a pe=1 cycle, using that cycle's h_cnt/v_cnt/beat.
- Latency: beat accepted at edge N appears on VGA_R/G/B after edge N and holds 2 clks.
- VGA_CLK <= ~pe, so VGA_CLK falls with the data change and rises one clk (20 ns) later, mid-eye.
- Frame period 800*525*2 = 840000 clks.
- Reset mid-frame: everything returns to its reset value at the next edge, and the FSM returns to RESYNC.

## Configuration
- VGA_STREAM_OUT_ERR_CNT_EN defined: adds output err_count[15:0], reset 0. It increments by 1 on each ACTIVE->RESYNC transition and saturates at 16'hFFFF.
- Not defined: the port and counter are absent; fault behaviour is otherwise identical.

## Test plan
- Reset held 4 clks, released, no input -> in_ready=1 in RESYNC; first HS falling edge after 656*2 clks; VS low during lines 490-491; visible pixels ERR_RGB 0000FF.
- Continuous well-formed frames with pixel = {h[7:0],v[7:0],8'hA5} -> from the second frame, every visible pixel matches its coordinate 1 clk after acceptance; no return to RESYNC across 3 frames.
- Source stalls (valid=0) at pixel (100,50) -> ERR_RGB from (100,50) onward; resync on the next sop at (0,0); err_count=1 when the macro is enabled.
- eop asserted early on (638,479) -> RESYNC; next frame displays correctly after sop.
- Stream of garbage beats followed by a sop 200 cycles later -> garbage consumed, sop held with in_ready=0 until the origin slot, then consumed at (0,0).
- reset_n pulsed low mid-line at h_cnt=300 -> next cycle all outputs at reset values; raster restarts from (0,0).
